prf_regfile: RTL and testbench

- Physical register file that sits directly downstream of the two-port writeback arbiter. It consumes the first/second write streams produced by that arbiter.
- Holds 2^REG_ADDR_WIDTH physical registers with a per-entry ready (scoreboard) bit.
- Serves four combinational read ports with same-cycle write bypass.
- Accepts up to two rename allocations per cycle; an allocation clears the entry's ready bit.

---
 rtl/prf_regfile_pkg.sv | 8 +
 rtl/prf_regfile_read_bypass.sv | 45 ++++
 rtl/prf_regfile.sv | 128 ++++++++++++
 tb/tb_prf_regfile.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/prf_regfile_pkg.sv
// Shared constants for the physical register file: default widths, the
// hardwired zero register index and the number of read ports.
package prf_regfile_pkg;
    localparam int PRF_ADDR_WIDTH = 6;
    localparam int PRF_DATA_WIDTH = 64;
    localparam int PRF_ZERO_REG   = 0;
    localparam int PRF_NUM_READ   = 4;
endpackage

// File: rtl/prf_regfile_read_bypass.sv
// One combinational read port: selects same-cycle write data over array
// contents, with the zero register and reset forcing data 0 / ready 1.
module prf_read_bypass
    import prf_regfile_pkg::*;
#(
    parameter int AW = PRF_ADDR_WIDTH,
    parameter int DW = PRF_DATA_WIDTH
) (
    input  logic          byp_en_i,
    input  logic [AW-1:0] rd_addr_i,
    input  logic          wr_a_valid_i,
    input  logic [AW-1:0] wr_a_addr_i,
    input  logic [DW-1:0] wr_a_data_i,
    input  logic          wr_b_valid_i,
    input  logic [AW-1:0] wr_b_addr_i,
    input  logic [DW-1:0] wr_b_data_i,
    input  logic [DW-1:0] arr_data_i,
    input  logic          arr_ready_i,
    output logic [DW-1:0] rd_data_o,
    output logic          rd_ready_o
);
    logic is_zero;
    logic hit_a;
    logic hit_b;

    assign is_zero = (rd_addr_i == AW'(PRF_ZERO_REG));
    assign hit_a   = wr_a_valid_i && (wr_a_addr_i == rd_addr_i);
    assign hit_b   = wr_b_valid_i && (wr_b_addr_i == rd_addr_i);

    // The second write port wins, matching the data the array will store.
    always_comb begin
        rd_data_o  = arr_data_i;
        rd_ready_o = arr_ready_i;
        if (!byp_en_i || is_zero) begin
            rd_data_o  = '0;
            rd_ready_o = 1'b1;
        end else if (hit_b) begin
            rd_data_o  = wr_b_data_i;
            rd_ready_o = 1'b1;
        end else if (hit_a) begin
            rd_data_o  = wr_a_data_i;
            rd_ready_o = 1'b1;
        end
    end
endmodule

// File: rtl/prf_regfile.sv
// Physical register file with per-entry ready bits, two write ports, two
// rename allocation ports, flush recovery and four bypassed read ports.
module prf_regfile
    import prf_regfile_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = PRF_ADDR_WIDTH,
    parameter int REG_DATA_WIDTH = PRF_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      wr_first_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wr_first_address,
    input  logic [REG_DATA_WIDTH-1:0] wr_first_data,
    input  logic                      wr_second_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wr_second_address,
    input  logic [REG_DATA_WIDTH-1:0] wr_second_data,
    input  logic                      alloc0_valid,
    input  logic [REG_ADDR_WIDTH-1:0] alloc0_address,
    input  logic                      alloc1_valid,
    input  logic [REG_ADDR_WIDTH-1:0] alloc1_address,
    input  logic                      flush,
    input  logic [REG_ADDR_WIDTH-1:0] rd0_address,
    input  logic [REG_ADDR_WIDTH-1:0] rd1_address,
    input  logic [REG_ADDR_WIDTH-1:0] rd2_address,
    input  logic [REG_ADDR_WIDTH-1:0] rd3_address,
    output logic [REG_DATA_WIDTH-1:0] rd0_data,
    output logic [REG_DATA_WIDTH-1:0] rd1_data,
    output logic [REG_DATA_WIDTH-1:0] rd2_data,
    output logic [REG_DATA_WIDTH-1:0] rd3_data,
    output logic                      rd0_ready,
    output logic                      rd1_ready,
    output logic                      rd2_ready,
    output logic                      rd3_ready
);
    localparam int AW       = REG_ADDR_WIDTH;
    localparam int DW       = REG_DATA_WIDTH;
    localparam int NUM_REGS = 1 << AW;
    localparam logic [AW-1:0] ZERO = AW'(PRF_ZERO_REG);

    // Valid/ready contract: there is no ready toward the producers. Any
    // write or alloc whose valid is high at a rising edge is taken.
    logic [DW-1:0]       data_q [NUM_REGS];
    logic [DW-1:0]       data_d [NUM_REGS];
    logic [NUM_REGS-1:0] ready_q;
    logic [NUM_REGS-1:0] ready_d;

    logic wa_en, wb_en, al0_en, al1_en;

    assign wa_en  = wr_first_valid  && (wr_first_address  != ZERO);
    assign wb_en  = wr_second_valid && (wr_second_address != ZERO);
    assign al0_en = alloc0_valid    && (alloc0_address    != ZERO);
    assign al1_en = alloc1_valid    && (alloc1_address    != ZERO);

    // Statement order sets ready priority: alloc last so it survives flush.
    always_comb begin
        data_d  = data_q;
        ready_d = ready_q;
        if (wa_en) begin
            data_d[wr_first_address]  = wr_first_data;
            ready_d[wr_first_address] = 1'b1;
        end
        if (wb_en) begin
            data_d[wr_second_address]  = wr_second_data;
            ready_d[wr_second_address] = 1'b1;
        end
        if (flush) begin
            ready_d = '1;
        end
        if (al0_en) begin
            ready_d[alloc0_address] = 1'b0;
        end
        if (al1_en) begin
            ready_d[alloc1_address] = 1'b0;
        end
        data_d[PRF_ZERO_REG]  = '0;
        ready_d[PRF_ZERO_REG] = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                data_q[i] <= '0;
            end
            ready_q <= '1;
        end else begin
            data_q  <= data_d;
            ready_q <= ready_d;
        end
    end

    logic [AW-1:0] rd_addr  [PRF_NUM_READ];
    logic [DW-1:0] rd_data  [PRF_NUM_READ];
    logic          rd_ready [PRF_NUM_READ];

    assign rd_addr[0] = rd0_address;
    assign rd_addr[1] = rd1_address;
    assign rd_addr[2] = rd2_address;
    assign rd_addr[3] = rd3_address;

    for (genvar p = 0; p < PRF_NUM_READ; p++) begin : g_rd
        prf_read_bypass #(
            .AW (AW),
            .DW (DW)
        ) u_byp (
            .byp_en_i     (rstn),
            .rd_addr_i    (rd_addr[p]),
            .wr_a_valid_i (wa_en),
            .wr_a_addr_i  (wr_first_address),
            .wr_a_data_i  (wr_first_data),
            .wr_b_valid_i (wb_en),
            .wr_b_addr_i  (wr_second_address),
            .wr_b_data_i  (wr_second_data),
            .arr_data_i   (data_q[rd_addr[p]]),
            .arr_ready_i  (ready_q[rd_addr[p]]),
            .rd_data_o    (rd_data[p]),
            .rd_ready_o   (rd_ready[p])
        );
    end

    assign rd0_data  = rd_data[0];
    assign rd1_data  = rd_data[1];
    assign rd2_data  = rd_data[2];
    assign rd3_data  = rd_data[3];
    assign rd0_ready = rd_ready[0];
    assign rd1_ready = rd_ready[1];
    assign rd2_ready = rd_ready[2];
    assign rd3_ready = rd_ready[3];
endmodule

// File: tb/tb_prf_regfile.sv
// Directed bench for prf_regfile: a per-cycle vector table plus hand-written
// reset sequences, each vector checking all four read ports.
module tb_prf_regfile;
    localparam int AW = 6;
    localparam int DW = 64;
    localparam int NV = 18;

    typedef struct packed {
        logic                wfv;
        logic [AW-1:0]       wfa;
        logic [DW-1:0]       wfd;
        logic                wsv;
        logic [AW-1:0]       wsa;
        logic [DW-1:0]       wsd;
        logic                a0v;
        logic [AW-1:0]       a0a;
        logic                a1v;
        logic [AW-1:0]       a1a;
        logic                fl;
        logic [3:0][AW-1:0]  ra;
        logic [3:0][DW-1:0]  ed;
        logic [3:0]          er;
    } vec_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          wfv, wsv, a0v, a1v, fl;
    logic [AW-1:0] wfa, wsa, a0a, a1a;
    logic [DW-1:0] wfd, wsd;
    logic [AW-1:0] ra [4];
    logic [DW-1:0] got_d [4];
    logic          got_r [4];

    vec_t vec [NV];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    prf_regfile dut (
        .clk               (clk),
        .rstn              (rstn),
        .wr_first_valid    (wfv),
        .wr_first_address  (wfa),
        .wr_first_data     (wfd),
        .wr_second_valid   (wsv),
        .wr_second_address (wsa),
        .wr_second_data    (wsd),
        .alloc0_valid      (a0v),
        .alloc0_address    (a0a),
        .alloc1_valid      (a1v),
        .alloc1_address    (a1a),
        .flush             (fl),
        .rd0_address       (ra[0]),
        .rd1_address       (ra[1]),
        .rd2_address       (ra[2]),
        .rd3_address       (ra[3]),
        .rd0_data          (got_d[0]),
        .rd1_data          (got_d[1]),
        .rd2_data          (got_d[2]),
        .rd3_data          (got_d[3]),
        .rd0_ready         (got_r[0]),
        .rd1_ready         (got_r[1]),
        .rd2_ready         (got_r[2]),
        .rd3_ready         (got_r[3])
    );

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_port(input string tag, input int p, input logic [DW-1:0] ed, input logic er);
        check($sformatf("%s rd%0d_data", tag, p), got_d[p], ed);
        check($sformatf("%s rd%0d_ready", tag, p), DW'(got_r[p]), DW'(er));
    endtask

    task automatic idle_inputs();
        wfv = 0; wfa = '0; wfd = '0;
        wsv = 0; wsa = '0; wsd = '0;
        a0v = 0; a0a = '0; a1v = 0; a1a = '0;
        fl = 0;
        for (int p = 0; p < 4; p++) ra[p] = '0;
    endtask

    task automatic drive(input vec_t v);
        wfv = v.wfv; wfa = v.wfa; wfd = v.wfd;
        wsv = v.wsv; wsa = v.wsa; wsd = v.wsd;
        a0v = v.a0v; a0a = v.a0a; a1v = v.a1v; a1a = v.a1a;
        fl  = v.fl;
        for (int p = 0; p < 4; p++) ra[p] = v.ra[p];
    endtask

    task automatic set_rd(input int i, input int p, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic r);
        vec[i].ra[p] = a;
        vec[i].ed[p] = d;
        vec[i].er[p] = r;
    endtask

    initial begin
        // Default every vector to idle inputs and all ports reading entry 0.
        for (int i = 0; i < NV; i++) begin
            vec[i]    = '0;
            vec[i].er = 4'hF;
        end
        // 0: first port writes 0xDEAD to 5, bypass visible this cycle
        vec[0].wfv = 1; vec[0].wfa = 5; vec[0].wfd = 64'hDEAD;
        set_rd(0, 0, 5, 64'hDEAD, 1); set_rd(0, 2, 9, 0, 1); set_rd(0, 3, 12, 0, 1);
        // 1: array read of 5
        set_rd(1, 0, 5, 64'hDEAD, 1); set_rd(1, 1, 9, 0, 1);
        // 2: dual write to 9, second port wins
        vec[2].wfv = 1; vec[2].wfa = 9; vec[2].wfd = 64'h11;
        vec[2].wsv = 1; vec[2].wsa = 9; vec[2].wsd = 64'h22;
        set_rd(2, 0, 9, 64'h22, 1); set_rd(2, 1, 5, 64'hDEAD, 1);
        // 3: alloc0 to 12, not yet visible
        vec[3].a0v = 1; vec[3].a0a = 12;
        set_rd(3, 0, 9, 64'h22, 1); set_rd(3, 1, 12, 0, 1); set_rd(3, 2, 5, 64'hDEAD, 1);
        // 4: entry 12 now not ready
        set_rd(4, 0, 9, 64'h22, 1); set_rd(4, 1, 12, 0, 0);
        // 5: second port writes 7 to 12, bypass gives ready 1
        vec[5].wsv = 1; vec[5].wsa = 12; vec[5].wsd = 64'h7;
        set_rd(5, 1, 12, 64'h7, 1);
        // 6: array ready for 12
        set_rd(6, 1, 12, 64'h7, 1);
        // 7: write and allocs to entry 0 are ignored
        vec[7].wfv = 1; vec[7].wfa = 0; vec[7].wfd = 64'hFFFF;
        vec[7].a0v = 1; vec[7].a0a = 0; vec[7].a1v = 1; vec[7].a1a = 0;
        set_rd(7, 2, 0, 0, 1);
        // 8: entry 0 still 0 / ready
        set_rd(8, 2, 0, 0, 1); set_rd(8, 3, 12, 64'h7, 1);
        // 9: alloc 3 and 4
        vec[9].a0v = 1; vec[9].a0a = 3; vec[9].a1v = 1; vec[9].a1a = 4;
        set_rd(9, 0, 3, 0, 1); set_rd(9, 1, 4, 0, 1);
        // 10: flush with alloc1 to 4
        vec[10].fl = 1; vec[10].a1v = 1; vec[10].a1a = 4;
        set_rd(10, 0, 3, 0, 0); set_rd(10, 1, 4, 0, 0);
        // 11: flush restored 3, alloc kept 4 cleared
        set_rd(11, 0, 3, 0, 1); set_rd(11, 1, 4, 0, 0);
        // 12: alloc and write same entry 20
        vec[12].a0v = 1; vec[12].a0a = 20; vec[12].wfv = 1; vec[12].wfa = 20; vec[12].wfd = 64'hAB;
        set_rd(12, 0, 20, 64'hAB, 1);
        // 13: data stored, alloc wins the ready bit
        set_rd(13, 0, 20, 64'hAB, 0);
        // 14: independent writes on both ports
        vec[14].wfv = 1; vec[14].wfa = 21; vec[14].wfd = 64'h100;
        vec[14].wsv = 1; vec[14].wsa = 22; vec[14].wsd = 64'h200;
        set_rd(14, 0, 21, 64'h100, 1); set_rd(14, 1, 22, 64'h200, 1);
        set_rd(14, 2, 63, 0, 1); set_rd(14, 3, 21, 64'h100, 1);
        // 15
        set_rd(15, 0, 21, 64'h100, 1); set_rd(15, 1, 22, 64'h200, 1);
        set_rd(15, 2, 4, 0, 0); set_rd(15, 3, 12, 64'h7, 1);
        // 16: flush alone plus a write to 23
        vec[16].fl = 1; vec[16].wfv = 1; vec[16].wfa = 23; vec[16].wfd = 64'h55;
        set_rd(16, 2, 4, 0, 0); set_rd(16, 3, 23, 64'h55, 1);
        // 17: everything ready after flush, write data kept
        set_rd(17, 0, 20, 64'hAB, 1); set_rd(17, 2, 4, 0, 1); set_rd(17, 3, 23, 64'h55, 1);

        // Reset held two cycles, with a write attempted during it.
        idle_inputs();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        ra[0] = 0; ra[1] = 5; ra[2] = 63; ra[3] = 5;
        wfv = 1; wfa = 5; wfd = 64'hBEEF;
        #1;
        check_port("rst", 0, 0, 1);
        check_port("rst", 1, 0, 1);
        check_port("rst", 2, 0, 1);
        check_port("rst", 3, 0, 1);
        @(negedge clk);
        idle_inputs();
        rstn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vec[i]);
            #1;
            for (int p = 0; p < 4; p++) begin
                check_port($sformatf("v%0d", i), p, vec[i].ed[p], vec[i].er[p]);
            end
        end

        // Reset asserted mid-cycle while a write to 7 is pending.
        @(negedge clk);
        idle_inputs();
        wfv = 1; wfa = 7; wfd = 64'h77;
        ra[0] = 7; ra[1] = 5; ra[2] = 12;
        #1;
        check_port("midrst_pre", 0, 64'h77, 1);
        #2;
        rstn = 1'b0;
        #1;
        check_port("midrst_hold", 0, 0, 1);
        check_port("midrst_hold", 1, 0, 1);
        @(negedge clk);
        idle_inputs();
        ra[0] = 7; ra[1] = 5; ra[2] = 12; ra[3] = 4;
        rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_port("midrst_post", 0, 0, 1);
        check_port("midrst_post", 1, 0, 1);
        check_port("midrst_post", 2, 0, 1);
        check_port("midrst_post", 3, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
